writeback_unit: RTL and testbench
=================================

Name: writeback_unit

Overview:
- Per-thread writeback stage that produces the register file write port (rd_addr, data_in, reg_input_mux, reg_write_enable) from ALU, LSU or immediate results.
- Accepts one writeback request per instruction from the decoder/issue logic.
- Waits for the LSU response when the source is memory, with a timeout.
- Holds the write until the scheduler's REQUEST window (core_state == 3'b011), filters illegal and reserved-register writes, and reports completion to the scheduler.

Parameters:
- DATA_W, 8, data width of results and register file data.
- ADDR_W, 4, register address width (16 registers).
- LSU_TIMEOUT, 64, maximum cycles spent waiting for an LSU response before aborting.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- enable  input  1  thread enable from core; gates the commit
- core_state  input  3  scheduler pipeline state; commit only when 3'b011 (REQUEST)
- flush  input  1  abort the in-flight writeback with no write
- issue_valid  input  1  writeback request valid
- issue_ready  output  1  block can accept a request
- issue_we  input  1  instruction writes a register
- issue_src  input  2  00 ALU, 01 LSU, 10 immediate, 11 illegal
- issue_rd  input  ADDR_W  destination register
- alu_result  input  DATA_W  ALU result, sampled at issue
- imm_value  input  DATA_W  immediate, sampled at issue
- lsu_resp_valid  input  1  LSU read data valid
- lsu_resp_data  input  DATA_W  LSU read data
- lsu_resp_ready  output  1  block accepts an LSU response
- rd_addr  output  ADDR_W  register file destination address
- data_in  output  DATA_W  register file write data
- reg_input_mux  output  2  captured source code, forwarded to the register file
- reg_write_enable  output  1  write pending toward the register file
- wb_done  output  1  one-cycle pulse when the instruction's writeback is finished (committed, skipped or dropped)
- err_reserved  output  1  one-cycle pulse: write to R13/R14/R15 dropped
- err_illegal  output  1  one-cycle pulse: issue_src == 11 dropped
- err_timeout  output  1  one-cycle pulse: LSU wait aborted

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - State becomes IDLE; timeout counter = 0.
  - rd_addr, data_in, reg_input_mux, reg_write_enable, wb_done and all err_* become 0.
  - issue_ready and lsu_resp_ready are 0 while reset is high.
  - Reset mid-operation discards any captured request with no write.
- State machine IDLE / WAIT_LSU / PENDING:
  - IDLE: issue_ready=1. On an edge with issue_valid=1, in priority order:
    - issue_we=0: no capture; wb_done pulses next cycle; stay IDLE.
    - issue_src=11: err_illegal and wb_done pulse next cycle; stay IDLE.
    - issue_rd in {13,14,15}: err_reserved and wb_done pulse next cycle; stay IDLE. This check applies to every source, including LSU, so no memory wait is started.
    - src 00 or 10: capture rd, src and data (alu_result or imm_value); go to PENDING.
    - src 01: capture rd and src; clear the counter; go to WAIT_LSU.
  - WAIT_LSU: lsu_resp_ready=1, issue_ready=0; the counter increments every cycle.
    - lsu_resp_valid=1: capture lsu_resp_data; go to PENDING. A response wins over timeout in the same cycle.
    - Else, when the counter reaches LSU_TIMEOUT-1: err_timeout and wb_done pulse; go to IDLE.
    - lsu_resp_valid while not in WAIT_LSU is ignored; lsu_resp_ready=0 there.
  - PENDING: reg_write_enable=1, with rd_addr, data_in and reg_input_mux stable.
    - At the edge where enable=1 and core_state=3'b011, the register file takes the write. The block goes to IDLE and pulses wb_done the next cycle; reg_write_enable drops to 0 in that same cycle.
    - Otherwise it holds indefinitely.
- flush=1 (highest priority after reset), in any state: go to IDLE; reg_write_enable=0 next cycle; no wb_done and no err pulse. A flush coincident with the commit edge cancels the write (reg_write_enable is deasserted from that edge; the commit is not counted).
- Latency:
  - ALU/immediate: issue edge → PENDING next cycle; commit at the first REQUEST edge after that.
  - LSU: response edge → PENDING next cycle.
- Throughput: a new issue is accepted only in IDLE. Minimum spacing is 2 cycles for committed ALU writes, and 1 cycle for skipped or dropped requests.
- Outputs are registered, except issue_ready and lsu_resp_ready, which decode the current state.

Test Plan:
- ALU write: issue src=00, rd=3, alu_result=0x5A; core_state=3'b011, enable=1 from the next cycle → reg_write_enable=1 with rd_addr=3, data_in=0x5A for exactly one cycle; wb_done pulses once; issue_ready returns to 1.
- LSU wait: issue src=01, rd=7; lsu_resp_valid after 5 cycles with data 0xC3; hold core_state=3'b010 for 3 more cycles, then 3'b011 → write of 0xC3 to rd 7 held until the REQUEST edge, then a single wb_done.
- Timeout: LSU_TIMEOUT=8, issue src=01, no response → err_timeout and wb_done pulse after 8 cycles of WAIT_LSU; reg_write_enable never asserted. Repeat with the response arriving on the last cycle → normal write, no error.
- Reserved/illegal: issue rd=14, src=10 → err_reserved and wb_done, no write. Issue src=11, rd=2 → err_illegal and wb_done, no write. Issue issue_we=0 → wb_done only.
- Flush/reset: enter PENDING with enable=0, then assert flush → reg_write_enable falls, no wb_done. Repeat in WAIT_LSU with reset → all outputs 0 next cycle; a later lsu_resp_valid is ignored.
- Back-to-back: issues to rd 1, 2, 3 (src 10, imm 0x11, 0x22, 0x33) with core_state held at 3'b011 → three commits in order, one every 2 cycles, exactly three wb_done pulses.

Source files
------------

// File: rtl/writeback_unit.sv
// rtl/writeback_unit.sv - per-thread register file writeback stage
// Captures ALU/immediate/LSU results and holds the write until the scheduler REQUEST window.
module writeback_unit #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 4,
  parameter int LSU_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [2:0]        core_state,
  input  logic              flush,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic              issue_we,
  input  logic [1:0]        issue_src,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] imm_value,
  input  logic              lsu_resp_valid,
  input  logic [DATA_W-1:0] lsu_resp_data,
  output logic              lsu_resp_ready,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] data_in,
  output logic [1:0]        reg_input_mux,
  output logic              reg_write_enable,
  output logic              wb_done,
  output logic              err_reserved,
  output logic              err_illegal,
  output logic              err_timeout
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_WAIT_LSU = 2'd1;
  localparam logic [1:0] ST_PENDING  = 2'd2;

  localparam logic [2:0] CORE_REQUEST = 3'b011;

  localparam int CNT_W = $clog2(LSU_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LSU_TIMEOUT - 1);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [1:0]        mux_q, mux_d;
  logic              we_q, we_d;
  logic              done_q, done_d;
  logic              err_res_q, err_res_d;
  logic              err_ill_q, err_ill_d;
  logic              err_to_q, err_to_d;
  logic              rd_reserved;

  assign rd_reserved = (issue_rd == ADDR_W'(13)) || (issue_rd == ADDR_W'(14)) ||
                       (issue_rd == ADDR_W'(15));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_d      = rd_q;
    data_d    = data_q;
    mux_d     = mux_q;
    we_d      = we_q;
    done_d    = 1'b0;
    err_res_d = 1'b0;
    err_ill_d = 1'b0;
    err_to_d  = 1'b0;
    if (flush) begin
      // Flush silently discards whatever is in flight, including a same-edge commit.
      state_d = ST_IDLE;
      we_d    = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (issue_valid) begin
            if (!issue_we) begin
              done_d = 1'b1;
            end else if (issue_src == 2'b11) begin
              err_ill_d = 1'b1;
              done_d    = 1'b1;
            end else if (rd_reserved) begin
              err_res_d = 1'b1;
              done_d    = 1'b1;
            end else if (issue_src == 2'b01) begin
              rd_d    = issue_rd;
              mux_d   = issue_src;
              cnt_d   = '0;
              state_d = ST_WAIT_LSU;
            end else begin
              rd_d    = issue_rd;
              mux_d   = issue_src;
              data_d  = (issue_src == 2'b10) ? imm_value : alu_result;
              we_d    = 1'b1;
              state_d = ST_PENDING;
            end
          end
        end
        ST_WAIT_LSU: begin
          // A response on the final wait cycle still beats the timeout.
          if (lsu_resp_valid) begin
            data_d  = lsu_resp_data;
            we_d    = 1'b1;
            state_d = ST_PENDING;
          end else if (cnt_q == CNT_LAST) begin
            err_to_d = 1'b1;
            done_d   = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_PENDING: begin
          if (enable && (core_state == CORE_REQUEST)) begin
            we_d    = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: begin
          we_d    = 1'b0;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rd_q      <= '0;
      data_q    <= '0;
      mux_q     <= '0;
      we_q      <= 1'b0;
      done_q    <= 1'b0;
      err_res_q <= 1'b0;
      err_ill_q <= 1'b0;
      err_to_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_q      <= rd_d;
      data_q    <= data_d;
      mux_q     <= mux_d;
      we_q      <= we_d;
      done_q    <= done_d;
      err_res_q <= err_res_d;
      err_ill_q <= err_ill_d;
      err_to_q  <= err_to_d;
    end
  end

  assign issue_ready      = !reset && (state_q == ST_IDLE);
  assign lsu_resp_ready   = !reset && (state_q == ST_WAIT_LSU);
  assign rd_addr          = rd_q;
  assign data_in          = data_q;
  assign reg_input_mux    = mux_q;
  assign reg_write_enable = we_q;
  assign wb_done          = done_q;
  assign err_reserved     = err_res_q;
  assign err_illegal      = err_ill_q;
  assign err_timeout      = err_to_q;

endmodule

// File: tb/tb_writeback_unit.sv
// tb/tb_writeback_unit.sv - self-checking bench for writeback_unit
// Directed scenarios followed by random transactions scored against a transaction-level model.
module tb_writeback_unit;

  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       reset, enable, flush, issue_valid, issue_we, lsu_resp_valid;
  logic [2:0] core_state;
  logic [1:0] issue_src;
  logic [3:0] issue_rd;
  logic [7:0] alu_result, imm_value, lsu_resp_data;
  logic       issue_ready, lsu_resp_ready, reg_write_enable, wb_done;
  logic       err_reserved, err_illegal, err_timeout;
  logic [3:0] rd_addr;
  logic [7:0] data_in;
  logic [1:0] reg_input_mux;

  int checks = 0;
  int errors = 0;

  writeback_unit #(.DATA_W(8), .ADDR_W(4), .LSU_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .enable(enable), .core_state(core_state), .flush(flush),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_we(issue_we),
    .issue_src(issue_src), .issue_rd(issue_rd), .alu_result(alu_result),
    .imm_value(imm_value), .lsu_resp_valid(lsu_resp_valid), .lsu_resp_data(lsu_resp_data),
    .lsu_resp_ready(lsu_resp_ready), .rd_addr(rd_addr), .data_in(data_in),
    .reg_input_mux(reg_input_mux), .reg_write_enable(reg_write_enable), .wb_done(wb_done),
    .err_reserved(err_reserved), .err_illegal(err_illegal), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic we, input logic [1:0] src, input logic [3:0] rd,
                       input logic [7:0] alu, input logic [7:0] imm);
    issue_valid = 1'b1;
    issue_we    = we;
    issue_src   = src;
    issue_rd    = rd;
    alu_result  = alu;
    imm_value   = imm;
    step();
    issue_valid = 1'b0;
  endtask

  // Random-phase scratch state
  logic [1:0] r_src;
  logic [3:0] r_rd;
  logic [7:0] r_alu, r_imm, r_lsu, exp_data;
  logic       r_we, exp_write, exp_ill, exp_res, exp_to, seen_write, seen_done;
  logic [3:0] seen_rd;
  logic [7:0] seen_data;
  logic [1:0] seen_mux;
  int         r_delay, r_stall, done_cnt, hi_cnt;

  task automatic observe();
    if (reg_write_enable) begin
      seen_write = 1'b1;
      seen_rd    = rd_addr;
      seen_data  = data_in;
      seen_mux   = reg_input_mux;
    end
    if (wb_done) seen_done = 1'b1;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; flush = 1'b0; issue_valid = 1'b0; issue_we = 1'b0;
    lsu_resp_valid = 1'b0; core_state = 3'b000; issue_src = 2'b00; issue_rd = 4'd0;
    alu_result = 8'h00; imm_value = 8'h00; lsu_resp_data = 8'h00;
    step(); step();
    chk("rst_issue_ready", 32'(issue_ready), 32'd0);
    chk("rst_lsu_ready", 32'(lsu_resp_ready), 32'd0);
    chk("rst_outputs", 32'({rd_addr, data_in, reg_input_mux, reg_write_enable, wb_done,
                             err_reserved, err_illegal, err_timeout}), 32'd0);
    reset = 1'b0;
    step();
    chk("idle_issue_ready", 32'(issue_ready), 32'd1);

    // ALU write committed at the first REQUEST edge
    core_state = 3'b011; enable = 1'b1;
    issue(1'b1, 2'b00, 4'd3, 8'h5A, 8'h00);
    chk("alu_pending", 32'({reg_write_enable, rd_addr, data_in, reg_input_mux, wb_done}),
        32'({1'b1, 4'd3, 8'h5A, 2'b00, 1'b0}));
    chk("alu_busy", 32'(issue_ready), 32'd0);
    step();
    chk("alu_commit", 32'({reg_write_enable, wb_done, issue_ready}), 32'b011);
    step();
    chk("alu_done_once", 32'(wb_done), 32'd0);

    // LSU response then held until REQUEST
    core_state = 3'b010;
    issue(1'b1, 2'b01, 4'd7, 8'h00, 8'h00);
    chk("lsu_wait_ready", 32'({lsu_resp_ready, issue_ready, reg_write_enable}), 32'b100);
    hi_cnt = 0;
    for (int i = 0; i < 4; i++) begin step(); if (reg_write_enable) hi_cnt++; end
    lsu_resp_valid = 1'b1; lsu_resp_data = 8'hC3;
    step();
    lsu_resp_valid = 1'b0;
    chk("lsu_no_early_write", 32'(hi_cnt), 32'd0);
    chk("lsu_pending", 32'({reg_write_enable, rd_addr, data_in, reg_input_mux}),
        32'({1'b1, 4'd7, 8'hC3, 2'b01}));
    hi_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (reg_write_enable) hi_cnt++;
      if (wb_done) done_cnt++;
    end
    chk("lsu_hold", 32'({hi_cnt[3:0], done_cnt[3:0]}), 32'h30);
    core_state = 3'b011;
    step();
    chk("lsu_commit", 32'({reg_write_enable, wb_done}), 32'b01);
    core_state = 3'b010;
    step();
    chk("lsu_done_once", 32'(wb_done), 32'd0);

    // LSU timeout after TO wait cycles
    issue(1'b1, 2'b01, 4'd5, 8'h00, 8'h00);
    hi_cnt = 0; done_cnt = 0;
    for (int i = 0; i < TO - 1; i++) begin
      step();
      if (reg_write_enable) hi_cnt++;
      if (wb_done || err_timeout) done_cnt++;
    end
    chk("to_quiet", 32'({hi_cnt[3:0], done_cnt[3:0]}), 32'h00);
    step();
    chk("to_fire", 32'({err_timeout, wb_done, reg_write_enable, issue_ready}), 32'b1101);
    step();
    chk("to_pulse", 32'({err_timeout, wb_done}), 32'b00);

    // Response on the last wait cycle wins over timeout
    issue(1'b1, 2'b01, 4'd6, 8'h00, 8'h00);
    for (int i = 0; i < TO - 1; i++) step();
    lsu_resp_valid = 1'b1; lsu_resp_data = 8'h9E;
    step();
    lsu_resp_valid = 1'b0;
    chk("to_last_resp", 32'({reg_write_enable, data_in, err_timeout, wb_done}),
        32'({1'b1, 8'h9E, 1'b0, 1'b0}));
    core_state = 3'b011;
    step();
    chk("to_last_commit", 32'({wb_done, reg_write_enable}), 32'b10);

    // Reserved, illegal, no-write
    core_state = 3'b010;
    issue(1'b1, 2'b10, 4'd14, 8'h00, 8'h77);
    chk("reserved", 32'({err_reserved, wb_done, reg_write_enable, err_illegal}), 32'b1100);
    issue(1'b1, 2'b11, 4'd2, 8'h00, 8'h00);
    chk("illegal", 32'({err_illegal, wb_done, reg_write_enable, err_reserved}), 32'b1100);
    issue(1'b0, 2'b00, 4'd4, 8'h12, 8'h00);
    chk("no_we", 32'({wb_done, err_illegal, err_reserved, reg_write_enable}), 32'b1000);
    issue(1'b1, 2'b01, 4'd13, 8'h00, 8'h00);
    chk("reserved_lsu", 32'({err_reserved, wb_done, lsu_resp_ready}), 32'b110);
    step();

    // Flush in PENDING
    core_state = 3'b011; enable = 1'b0;
    issue(1'b1, 2'b00, 4'd9, 8'h44, 8'h00);
    chk("flush_pre", 32'(reg_write_enable), 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_drop", 32'({reg_write_enable, wb_done, issue_ready}), 32'b001);
    step();
    chk("flush_no_done", 32'({wb_done, err_reserved, err_illegal, err_timeout}), 32'd0);

    // Flush on the commit edge cancels the write
    enable = 1'b1;
    issue(1'b1, 2'b00, 4'd2, 8'hA5, 8'h00);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_commit", 32'({reg_write_enable, wb_done}), 32'b00);

    // Reset while waiting on LSU
    core_state = 3'b010;
    issue(1'b1, 2'b01, 4'd8, 8'h00, 8'h00);
    reset = 1'b1;
    step();
    chk("rst_wait", 32'({reg_write_enable, wb_done, err_timeout, rd_addr, data_in,
                         issue_ready, lsu_resp_ready}), 32'd0);
    reset = 1'b0; lsu_resp_valid = 1'b1; lsu_resp_data = 8'h3C;
    step();
    lsu_resp_valid = 1'b0;
    step();
    chk("rst_resp_ignored", 32'({reg_write_enable, wb_done, lsu_resp_ready}), 32'd0);

    // Back-to-back immediates with REQUEST held
    core_state = 3'b011; enable = 1'b1; done_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      issue(1'b1, 2'b10, 4'(i + 1), 8'h00, 8'(8'h11 * (i + 1)));
      chk("b2b_pending", 32'({reg_write_enable, rd_addr, data_in}),
          32'({1'b1, 4'(i + 1), 8'(8'h11 * (i + 1))}));
      step();
      if (wb_done) done_cnt++;
    end
    step();
    if (wb_done) done_cnt++;
    chk("b2b_done_count", 32'(done_cnt), 32'd3);

    // Random transactions against a transaction-level model
    for (int t = 0; t < 60; t++) begin
      r_we    = ($urandom_range(0, 7) != 0);
      r_src   = 2'($urandom_range(0, 3));
      r_rd    = 4'($urandom);
      r_alu   = 8'($urandom);
      r_imm   = 8'($urandom);
      r_lsu   = 8'($urandom);
      r_delay = $urandom_range(1, TO + 3);
      r_stall = $urandom_range(0, 5);
      exp_ill   = r_we && (r_src == 2'b11);
      exp_res   = r_we && !exp_ill && (r_rd >= 4'd13);
      exp_to    = r_we && !exp_ill && !exp_res && (r_src == 2'b01) && (r_delay > TO);
      exp_write = r_we && !exp_ill && !exp_res && !exp_to;
      exp_data  = (r_src == 2'b00) ? r_alu : (r_src == 2'b10) ? r_imm : r_lsu;
      seen_write = 1'b0; seen_done = 1'b0;
      seen_rd = 4'd0; seen_data = 8'd0; seen_mux = 2'd0;
      core_state = 3'b010; enable = 1'b0;
      issue(r_we, r_src, r_rd, r_alu, r_imm);
      observe();
      chk("rnd_err_flags", 32'({err_illegal, err_reserved}), 32'({exp_ill, exp_res}));
      for (int c = 1; c <= 40 && !seen_done; c++) begin
        lsu_resp_valid = (c == r_delay);
        lsu_resp_data  = r_lsu;
        core_state     = (c > r_stall) ? 3'b011 : 3'b010;
        enable         = (c > r_stall);
        step();
        observe();
        if (wb_done) chk("rnd_timeout_flag", 32'(err_timeout), 32'(exp_to));
      end
      lsu_resp_valid = 1'b0;
      chk("rnd_done_seen", 32'(seen_done), 32'd1);
      chk("rnd_write_seen", 32'(seen_write), 32'(exp_write));
      if (exp_write)
        chk("rnd_write_data", 32'({seen_rd, seen_data, seen_mux}),
            32'({r_rd, exp_data, r_src}));
      chk("rnd_we_after_done", 32'(reg_write_enable), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
